sump_cmd_parser: RTL and testbench

- Assembles SUMP-protocol command bytes from the serial/SPI receiver into the `opcode` / `config_data` / `execute` interface consumed by `core`.
- Sits between the byte-level UART/SPI receiver and `core`, and is the initiator side of the command interface that `core`'s decoder and flags registers respond to.
- Handles two command lengths:
  - short commands: 1 byte, opcode bit 7 = 0;
  - long commands: 5 bytes, opcode bit 7 = 1, followed by 4 data bytes, little-endian.
- Discards stalled partial long commands after a timeout.

---
 rtl/sump_cmd_parser.sv | 113 +++++++++++
 tb/tb_sump_cmd_parser.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sump_cmd_parser.sv
// sump_cmd_parser
//   Builds SUMP commands out of the byte stream from the UART/SPI receiver.
//   A short command is one byte with bit 7 clear. A long command is an opcode
//   byte with bit 7 set, followed by four argument bytes, least significant
//   byte first. A long command that stalls between bytes for TIMEOUT_CYCLES
//   clocks is dropped. Setting TIMEOUT_CYCLES to 0 disables the timeout.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   rx_valid     one-cycle strobe; rx_data holds a received byte
//   rx_data      received byte
//   opcode       command opcode; valid while execute is high, then held
//   config_data  command argument; valid while execute is high, then held
//   execute      one-cycle pulse when opcode/config_data hold a complete command
//   cmd_busy     high while a long command is partially received
//   timeout_err  one-cycle pulse when a partial long command is discarded
module sump_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  opcode,
    output logic [31:0] config_data,
    output logic        execute,
    output logic        cmd_busy,
    output logic        timeout_err
);

    // The idle counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] LIMIT_V = TW'(LIMIT);

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    state_t        state;
    logic [7:0]    op_hold;
    logic [23:0]   data_hold;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            opcode      <= '0;
            config_data <= '0;
            execute     <= 1'b0;
            cmd_busy    <= 1'b0;
            timeout_err <= 1'b0;
            op_hold     <= '0;
            data_hold   <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            execute     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (!rx_data[7]) begin
                            opcode      <= rx_data;
                            config_data <= '0;
                            execute     <= 1'b1;
                        end else begin
                            // Visible outputs stay untouched until the whole
                            // long command has arrived.
                            op_hold  <= rx_data;
                            byte_cnt <= '0;
                            tmo_cnt  <= '0;
                            cmd_busy <= 1'b1;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        // A byte that lands in the limit cycle still counts.
                        tmo_cnt  <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: data_hold[7:0]   <= rx_data;
                            2'd1: data_hold[15:8]  <= rx_data;
                            2'd2: data_hold[23:16] <= rx_data;
                            default: begin
                                opcode      <= op_hold;
                                config_data <= {rx_data, data_hold};
                                execute     <= 1'b1;
                                cmd_busy    <= 1'b0;
                                state       <= IDLE;
                            end
                        endcase
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (tmo_cnt == LIMIT_V) begin
                            timeout_err <= 1'b1;
                            cmd_busy    <= 1'b0;
                            state       <= IDLE;
                        end else if (tmo_cnt != '1) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sump_cmd_parser.sv
// Testbench for sump_cmd_parser. The driver feeds bytes one clock at a time
// and keeps a byte-queue model of the command protocol. That model pushes
// the expected execute/timeout events onto a scoreboard. A separate monitor
// pops the events and compares them whenever the DUT pulses execute or
// timeout_err. It also compares the held outputs and cmd_busy every cycle.
module tb_sump_cmd_parser;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  opcode;
    logic [31:0] config_data;
    logic        execute;
    logic        cmd_busy;
    logic        timeout_err;

    sump_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .opcode      (opcode),
        .config_data (config_data),
        .execute     (execute),
        .cmd_busy    (cmd_busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_tmo;
        logic [7:0]  op;
        logic [31:0] cfg;
        int          due;
    } exp_t;

    exp_t sb[$];

    // Protocol model: bytes of the long command being received.
    logic [7:0]  pend[$];
    int          idle_cnt = 0;
    logic [7:0]  held_op = 8'h00;
    logic [31:0] held_cfg = 32'h0;
    bit          exp_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one clock of input for the next rising edge and advance the model.
    task automatic step(input bit v, input logic [7:0] b);
        @(posedge clock);
        #2;
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
        if (pend.size() == 0) begin
            if (v) begin
                if (!b[7]) begin
                    held_op  = b;
                    held_cfg = 32'h0;
                    sb.push_back('{is_tmo: 1'b0, op: b, cfg: 32'h0, due: cyc + 1});
                end else begin
                    pend.push_back(b);
                    idle_cnt = 0;
                end
            end
        end else if (v) begin
            pend.push_back(b);
            idle_cnt = 0;
            if (pend.size() == 5) begin
                held_op  = pend[0];
                held_cfg = {pend[4], pend[3], pend[2], pend[1]};
                sb.push_back('{is_tmo: 1'b0, op: held_op, cfg: held_cfg, due: cyc + 1});
                pend.delete();
            end
        end else begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                sb.push_back('{is_tmo: 1'b1, op: held_op, cfg: held_cfg, due: cyc + 1});
                pend.delete();
            end
        end
        exp_busy = (pend.size() != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$], input int max_gap);
        foreach (bytes[i]) begin
            step(1'b1, bytes[i]);
            idle($urandom_range(0, max_gap));
        end
    endtask

    // Monitor: per-cycle held-output checks plus scoreboard matching.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            check("cmd_busy", {63'h0, cmd_busy}, {63'h0, exp_busy});
            check("opcode_held", {56'h0, opcode}, {56'h0, held_op});
            check("config_held", {32'h0, config_data}, {32'h0, held_cfg});
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check("missing_event", 64'(cyc), 64'(e.due));
            end
            if (execute || timeout_err) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    check("unexpected_event", {62'h0, execute, timeout_err}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    check("execute_pulse", {63'h0, execute}, {63'h0, !e.is_tmo});
                    check("timeout_pulse", {63'h0, timeout_err}, {63'h0, e.is_tmo});
                    check("event_opcode", {56'h0, opcode}, {56'h0, e.op});
                    check("event_config", {32'h0, config_data}, {32'h0, e.cfg});
                end
            end
        end
    end

    initial begin
        logic [7:0] q[$];

        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;

        // Short command.
        step(1'b1, 8'h01);
        idle(4);

        // Long command with random gaps.
        q = '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
        send_bytes(q, 3);
        idle(4);

        // Stall after one data byte, then a short command.
        step(1'b1, 8'h81);
        step(1'b1, 8'hAA);
        idle(22);
        step(1'b1, 8'h02);
        idle(3);

        // Bytes land exactly on the limit cycle twice.
        step(1'b1, 8'h85);
        step(1'b1, 8'h11);
        idle(TMO - 1);
        step(1'b1, 8'h22);
        idle(TMO - 1);
        step(1'b1, 8'h33);
        step(1'b1, 8'h44);
        idle(3);

        // Back-to-back traffic.
        q = '{8'h82, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11};
        send_bytes(q, 0);
        idle(3);

        // SUMP reset sequence.
        q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(q, 0);
        idle(2);

        // Reset mid-command.
        step(1'b1, 8'h80);
        step(1'b1, 8'hFF);
        @(posedge clock);
        #2;
        rx_valid = 1'b0;
        reset    = 1'b1;
        pend.delete();
        idle_cnt = 0;
        held_op  = 8'h00;
        held_cfg = 32'h0;
        exp_busy = 1'b0;
        #1;
        check("rst_opcode", {56'h0, opcode}, 64'h0);
        check("rst_config", {32'h0, config_data}, 64'h0);
        check("rst_busy", {63'h0, cmd_busy}, 64'h0);
        check("rst_execute", {63'h0, execute}, 64'h0);
        check("rst_timeout", {63'h0, timeout_err}, 64'h0);
        #13;
        reset = 1'b0;
        step(1'b1, 8'h00);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6) idle($urandom_range(10, TMO + 4));
            else step(r < 60, 8'($urandom));
        end

        idle(TMO + 4);
        check("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
